// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the serial-to-ROM loader.
// The optional trailing checksum byte is enabled with ROM_LOADER_CHECKSUM_EN.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck
    } state_e;

    localparam int unsigned ROM_LOADER_DEF_TIMEOUT = 2000000;
    localparam int unsigned ROM_LOADER_DEF_SIZE    = 16384;
    localparam int unsigned SYNC_STAGES            = 2;

endpackage

// File: rtl/rom_loader_sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
// Emits one clk-wide pulse per rising edge of an asynchronous level.
module rom_loader_sync_edge
    import rom_loader_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            last_q    <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q    <= sync_q[SYNC_STAGES-1];
            pulse_out <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Sequences ROM_SIZE serial bytes into consecutive ROM addresses, holding the CPU meanwhile.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing byte that zeroes the 8-bit data sum.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned ROM_SIZE = ROM_LOADER_DEF_SIZE,
    parameter int unsigned TIMEOUT  = ROM_LOADER_DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] prg_addr,
    output logic [7:0]        prg_data,
    output logic              prg_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned       CNT_W     = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT - 1);

    logic              byte_stb;
    state_e            state;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  tmo_cnt;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        data_sum;
    logic [7:0]        sum_next;

    assign sum_next = data_sum + rx_byte;
`else
    logic              finish;
`endif

    rom_loader_sync_edge u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .async_in  (rx_ready),
        .pulse_out (byte_stb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prg_addr  <= '0;
            prg_data  <= '0;
            prg_wren  <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            state     <= StIdle;
            next_addr <= '0;
            tmo_cnt   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            data_sum  <= '0;
`else
            finish    <= 1'b0;
`endif
        end else begin
            prg_wren <= 1'b0;
            done     <= 1'b0;
            if (byte_stb) prg_data <= rx_byte;

            unique case (state)
                StIdle: begin
                    tmo_cnt <= '0;
                    if (byte_stb) begin
                        prg_wren  <= 1'b1;
                        prg_addr  <= '0;
                        next_addr <= ADDR_W'(1);
                        error     <= 1'b0;
                        cpu_hold  <= 1'b1;
                        state     <= StLoad;
`ifdef ROM_LOADER_CHECKSUM_EN
                        data_sum  <= rx_byte;
`endif
                    end
                end

                StLoad: begin
                    if (byte_stb) begin
                        prg_wren  <= 1'b1;
                        prg_addr  <= next_addr;
                        next_addr <= next_addr + ADDR_W'(1);
                        tmo_cnt   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        data_sum  <= sum_next;
                        if (next_addr == LAST_ADDR) state <= StCheck;
`else
                        if (next_addr == LAST_ADDR) finish <= 1'b1;
`endif
                    end else if (tmo_cnt == CNT_MAX) begin
                        error    <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= StIdle;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

`ifdef ROM_LOADER_CHECKSUM_EN
                StCheck: begin
                    // Trailer byte is only compared, never written to the ROM.
                    if (byte_stb) begin
                        if (sum_next == 8'h00) done  <= 1'b1;
                        else                   error <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= StIdle;
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == CNT_MAX) begin
                        error    <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= StIdle;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
`endif

                default: state <= StIdle;
            endcase

`ifndef ROM_LOADER_CHECKSUM_EN
            // Strobe spacing guarantees no byte lands in the cycle after the last write.
            if (finish) begin
                finish   <= 1'b0;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
                state    <= StIdle;
                tmo_cnt  <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a write scoreboard (ROM_SIZE=16, TIMEOUT=100).
// Also exercises the trailer-byte path when ROM_LOADER_CHECKSUM_EN is defined.
module tb_rom_loader;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned ROM_SIZE = 16;
    localparam int unsigned TIMEOUT  = 100;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        int                cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic [ADDR_W-1:0] prg_addr;
    logic [7:0]        prg_data;
    logic              prg_wren;
    logic              cpu_hold;
    logic              done;
    logic              error;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   done_cnt;
    int   done_cyc;
    int   last_wren_cyc;
    int   m_addr;
    bit   m_active;
    logic prev_hold;
    logic [7:0] m_sum;

    rom_loader #(
        .ADDR_W   (ADDR_W),
        .ROM_SIZE (ROM_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .prg_addr (prg_addr),
        .prg_data (prg_data),
        .prg_wren (prg_wren),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge and retire any write against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (prg_wren === 1'b1) begin
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(prg_addr), 32'(e.addr));
                check("wr_data", 32'(prg_data), 32'(e.data));
                check("wr_latency", cyc - e.cyc, 4);
                check("hold_during_write", 32'(cpu_hold), 1);
            end
            last_wren_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("hold_low_at_done", 32'(cpu_hold), 0);
            check("hold_high_before_done", 32'(prev_hold), 1);
        end
        prev_hold = cpu_hold;
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        rx_byte  = b;
        rx_ready = 1'b1;
        if (!m_active) begin
            m_active = 1'b1;
            m_addr   = 0;
            m_sum    = 8'h00;
        end
        exp_q.push_back('{addr: ADDR_W'(m_addr), data: b, cyc: cyc});
        m_sum = m_sum + b;
        if (m_addr == ROM_SIZE - 1) m_active = 1'b0;
        else m_addr++;
        repeat (hold) tick();
        rx_ready = 1'b0;
        repeat (gap - hold) tick();
    endtask

    task automatic send_trailer(input logic [7:0] b);
        rx_byte  = b;
        rx_ready = 1'b1;
        repeat (2) tick();
        rx_ready = 1'b0;
        repeat (38) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(prg_addr), 0);
        check({tag, "_data"}, 32'(prg_data), 0);
        check({tag, "_wren"}, 32'(prg_wren), 0);
        check({tag, "_hold"}, 32'(cpu_hold), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
    endtask

    initial begin
        int d0;
        int waited;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        done_cnt      = 0;
        done_cyc      = 0;
        last_wren_cyc = 0;
        m_addr        = 0;
        m_active      = 1'b0;
        m_sum         = 8'h00;
        prev_hold     = 1'b0;
        reset         = 1'b1;
        rx_ready      = 1'b0;
        rx_byte       = 8'h00;

        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) tick();

        // Full session: data equals address.
        d0 = done_cnt;
        for (int i = 0; i < ROM_SIZE; i++) send(8'(i), 2, 40);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_trailer(8'(-m_sum));
`endif
        repeat (10) tick();
        check("s1_done_count", done_cnt - d0, 1);
`ifndef ROM_LOADER_CHECKSUM_EN
        check("s1_done_after_last_write", done_cyc - last_wren_cyc, 1);
`endif
        check("s1_hold_idle", 32'(cpu_hold), 0);
        check("s1_addr_holds", 32'(prg_addr), ROM_SIZE - 1);
        check("s1_no_error", 32'(error), 0);
        check("s1_queue_empty", exp_q.size(), 0);

        // Inter-byte timeout after five bytes.
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 2, 40);
        waited = 0;
        while (error !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        check("timeout_error_set", 32'(error), 1);
        check("timeout_latency", cyc - last_wren_cyc, TIMEOUT);
        check("timeout_hold_drop", 32'(cpu_hold), 0);
        check("timeout_no_done", done_cnt - d0, 0);
        m_active = 1'b0;

        // Next byte restarts at address 0 and clears the sticky error.
        send(8'hA5, 2, 40);
        check("restart_error_cleared", 32'(error), 0);
        check("restart_hold", 32'(cpu_hold), 1);
        for (int i = 1; i < 7; i++) send(8'(8'hA5 + i), 2, 40);

        // Reset in the middle of a session.
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset    = 1'b0;
        m_active = 1'b0;
        repeat (5) tick();

        // Held level gives one write, then a 4-cycle toggle gives one write per rise.
        d0 = done_cnt;
        send(8'h5A, 50, 60);
        check("level_one_write", exp_q.size(), 0);
        for (int i = 1; i < 5; i++) send(8'(8'h60 + i), 2, 4);
        for (int i = 5; i < ROM_SIZE; i++) send(8'(8'h70 + i), 2, 40);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_trailer(8'(-m_sum));
`endif
        repeat (10) tick();

        // Back-to-back good session must also start at address 0.
        for (int i = 0; i < ROM_SIZE; i++) send(8'(8'h80 + 3 * i), 2, 40);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_trailer(8'(-m_sum));
`endif
        repeat (10) tick();
        check("two_sessions_done", done_cnt - d0, 2);
        check("two_sessions_no_error", 32'(error), 0);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Wrong trailer: error, no done, no extra write.
        d0 = done_cnt;
        for (int i = 0; i < ROM_SIZE; i++) send(8'(i + 1), 2, 40);
        send_trailer(8'(8'h01 - m_sum));
        repeat (10) tick();
        check("bad_sum_error", 32'(error), 1);
        check("bad_sum_no_done", done_cnt - d0, 0);
        check("bad_sum_hold", 32'(cpu_hold), 0);
`endif

        repeat (20) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
